// File: rtl/dac_spi_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the APD high-voltage DAC serial transmitter:
// state encoding, frame geometry and a frame-duration helper.
package dac_spi_pkg;

   localparam int DEF_DATA_W = 10;
   localparam int DEF_PAD_W  = 2;
   localparam int FRAME_W    = DEF_DATA_W + DEF_PAD_W;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_SETUP = 5'b00010,
      ST_SHIFT = 5'b00100,
      ST_HOLD  = 5'b01000,
      ST_GAP   = 5'b10000
   } state_e;

   // Cycles chip select stays low: setup + 2 phases per bit + hold.
   function automatic int frame_cycles(input int clk_div, input int frame_w);
      return clk_div * (2 * frame_w + 2);
   endfunction

endpackage

// File: rtl/dac_spi_tx_if.sv
`timescale 1ns/1ps
// Request/pin bundle between the compensation block (master) and the
// DAC transmitter (slave).
interface dac_spi_tx_if #(
   parameter int DW = dac_spi_pkg::DEF_DATA_W
);
   logic          i_dac_start;
   logic [DW-1:0] i_dac_value;
   logic          o_dac_cs_n;
   logic          o_dac_sclk;
   logic          o_dac_din;
   logic          o_dac_busy;
   logic          o_dac_done;

   modport master (
      output i_dac_start, i_dac_value,
      input  o_dac_cs_n, o_dac_sclk, o_dac_din, o_dac_busy, o_dac_done
   );

   modport slave (
      input  i_dac_start, i_dac_value,
      output o_dac_cs_n, o_dac_sclk, o_dac_din, o_dac_busy, o_dac_done
   );
endinterface

// File: rtl/dac_spi_clkgen.sv
`timescale 1ns/1ps
// Half-period divider: counts 0..CLK_DIV-1 and flags the terminal count.
// clr restarts the count so every FSM state begins on a full phase.
module dac_spi_clkgen #(
   parameter int CLK_DIV = 5
) (
   input  logic i_clk_50m,
   input  logic i_rst,
   input  logic clr,
   output logic tick
);
   localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_reg;

   assign tick = (cnt_reg == CNT_LAST);

   always_ff @(posedge i_clk_50m) begin
      if (i_rst || clr || tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end
endmodule

// File: rtl/dac_spi_tx.sv
`timescale 1ns/1ps
// Serial transmitter for the 10-bit APD HV DAC: frames {code, zero pad}
// MSB-first under chip select, with a one-deep last-write-wins pending slot.
module dac_spi_tx
   import dac_spi_pkg::*;
#(
   parameter int CLK_DIV = 5,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int PAD_W   = DEF_PAD_W,
   parameter int CS_GAP  = 10
) (
   input  logic        i_clk_50m,
   input  logic        i_rst,
   dac_spi_tx_if.slave dac
);
   localparam int               FRM_W    = DATA_W + PAD_W;
   localparam int               BC_W     = $clog2(FRM_W);
   localparam int               GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(FRM_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

   state_e             state_reg, state_next;
   logic [FRM_W-1:0]   shift_reg, shift_next;
   logic [BC_W-1:0]    bit_cnt_reg, bit_cnt_next;
   logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
   logic               pend_reg, pend_next;
   logic [DATA_W-1:0]  pend_val_reg, pend_val_next;
   logic               cs_n_reg, cs_n_next;
   logic               sclk_reg, sclk_next;
   logic               din_reg, din_next;
   logic               busy_reg, busy_next;
   logic               done_reg, done_next;

   logic               tick;
   logic               div_clr;
   logic               gap_exit;
   logic               last_bit;
   logic               do_load;
   logic [FRM_W-1:0]   load_word;

   assign div_clr  = (state_next != state_reg);
   assign gap_exit = (state_reg == ST_GAP) && (gap_cnt_reg == GAP_LAST);
   assign last_bit = (bit_cnt_reg == BIT_LAST);
   assign do_load  = ((state_reg == ST_IDLE) && dac.i_dac_start) ||
                     (gap_exit && (dac.i_dac_start || pend_reg));
   // A fresh start always beats an older pending value at GAP exit.
   assign load_word = {(dac.i_dac_start ? dac.i_dac_value : pend_val_reg), {PAD_W{1'b0}}};

   dac_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .i_clk_50m (i_clk_50m),
      .i_rst     (i_rst),
      .clr       (div_clr),
      .tick      (tick)
   );

   always_ff @(posedge i_clk_50m) begin
      if (i_rst) begin
         state_reg    <= ST_IDLE;
         shift_reg    <= '0;
         bit_cnt_reg  <= '0;
         gap_cnt_reg  <= '0;
         pend_reg     <= 1'b0;
         pend_val_reg <= '0;
         cs_n_reg     <= 1'b1;
         sclk_reg     <= 1'b0;
         din_reg      <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         bit_cnt_reg  <= bit_cnt_next;
         gap_cnt_reg  <= gap_cnt_next;
         pend_reg     <= pend_next;
         pend_val_reg <= pend_val_next;
         cs_n_reg     <= cs_n_next;
         sclk_reg     <= sclk_next;
         din_reg      <= din_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (dac.i_dac_start) state_next = ST_SETUP;
         ST_SETUP: if (tick) state_next = ST_SHIFT;
         ST_SHIFT: if (tick && sclk_reg && last_bit) state_next = ST_HOLD;
         ST_HOLD:  if (tick) state_next = ST_GAP;
         ST_GAP:   if (gap_exit) state_next = (dac.i_dac_start || pend_reg) ? ST_SETUP : ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      shift_next    = shift_reg;
      bit_cnt_next  = bit_cnt_reg;
      gap_cnt_next  = gap_cnt_reg;
      pend_next     = pend_reg;
      pend_val_next = pend_val_reg;
      cs_n_next     = cs_n_reg;
      sclk_next     = sclk_reg;
      din_next      = din_reg;
      busy_next     = busy_reg;
      done_next     = 1'b0;

      if (dac.i_dac_start && busy_reg && !gap_exit) begin
         pend_next     = 1'b1;
         pend_val_next = dac.i_dac_value;
      end

      case (state_reg)
         ST_SHIFT: begin
            if (tick) begin
               if (!sclk_reg) begin
                  sclk_next = 1'b1;
               end else begin
                  sclk_next = 1'b0;
                  if (!last_bit) begin
                     shift_next   = shift_reg << 1;
                     din_next     = shift_reg[FRM_W-2];
                     bit_cnt_next = bit_cnt_reg + 1'b1;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               cs_n_next    = 1'b1;
               done_next    = 1'b1;
               din_next     = 1'b0;
               gap_cnt_next = '0;
            end
         end
         ST_GAP: begin
            gap_cnt_next = gap_cnt_reg + 1'b1;
            if (gap_exit) begin
               gap_cnt_next = '0;
               pend_next    = 1'b0;
               busy_next    = 1'b0;
            end
         end
         default: ;
      endcase

      if (do_load) begin
         shift_next   = load_word;
         din_next     = load_word[FRM_W-1];
         bit_cnt_next = '0;
         cs_n_next    = 1'b0;
         sclk_next    = 1'b0;
         busy_next    = 1'b1;
      end
   end

   assign dac.o_dac_cs_n = cs_n_reg;
   assign dac.o_dac_sclk = sclk_reg;
   assign dac.o_dac_din  = din_reg;
   assign dac.o_dac_busy = busy_reg;
   assign dac.o_dac_done = done_reg;
endmodule
